// File: rtl/alu_pkg.sv
// Shared types and defaults for the serial simple-ALU operand driver.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_TIMEOUT    = 64;

  // ALU operation encoding; bit 0 is serialised first.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PAR  = 2'b10,
    OP_COMP = 2'b11
  } alu_op_e;

  // Driver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_BEAT2 = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } drv_state_e;

  // Serial opcode bit carried during a given beat state (0 outside the beats).
  function automatic logic beat_opcode_bit(input drv_state_e st, input alu_op_e op);
    logic [1:0] op_bits;
    logic       bit_out;
    op_bits = 2'(op);
    bit_out = 1'b0;
    case (st)
      ST_BEAT0, ST_BEAT1: bit_out = op_bits[0];
      ST_BEAT2:           bit_out = op_bits[1];
      default:            bit_out = 1'b0;
    endcase
    return bit_out;
  endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Saturating WAIT-cycle counter; flags the cycle in which the count reaches TIMEOUT.
module alu_timeout_counter
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Count enabled cycles since the last clear, holding at TIMEOUT.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The increment taken this cycle brings the count to TIMEOUT.
  assign o_expired_c = i_enable && (r_count >= CNT_LAST);

endmodule

// File: rtl/alu_driver.sv
// Initiator-side master: serialises one request onto the ALU beat lines and returns its response.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  // ALU beat lines
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout
);

  drv_state_e            r_state;
  drv_state_e            w_state_nxt;
  alu_op_e               r_op;
  alu_op_e               w_op_nxt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] w_a_nxt;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] w_b_nxt;

  logic                  r_req_ready;
  logic                  w_req_ready_nxt;
  logic                  r_opcode_valid;
  logic                  w_opcode_valid_nxt;
  logic                  r_opcode;
  logic                  w_opcode_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic                  r_rsp_valid;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic [DATA_WIDTH-1:0] w_rsp_result_nxt;
  logic                  r_rsp_overflow;
  logic                  w_rsp_overflow_nxt;
  logic                  r_rsp_timeout;
  logic                  w_rsp_timeout_nxt;

  logic                  w_cnt_clear;
  logic                  w_cnt_enable;
  logic                  w_expired;

  alu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clear     (w_cnt_clear),
    .i_enable    (w_cnt_enable),
    .o_expired_c (w_expired)
  );

  // Next state, captured request/response fields, and outputs decoded from the next state.
  always_comb begin
    w_state_nxt        = r_state;
    w_op_nxt           = r_op;
    w_a_nxt            = r_a;
    w_b_nxt            = r_b;
    w_rsp_result_nxt   = r_rsp_result;
    w_rsp_overflow_nxt = r_rsp_overflow;
    w_rsp_timeout_nxt  = r_rsp_timeout;
    w_cnt_clear        = 1'b0;
    w_cnt_enable       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // r_req_ready gates acceptance so nothing is taken in the cycle leaving reset.
        if (r_req_ready && req_valid) begin
          w_op_nxt    = alu_op_e'(req_opcode);
          w_a_nxt     = req_a;
          w_b_nxt     = req_b;
          w_state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT0: w_state_nxt = ST_BEAT1;
      ST_BEAT1: w_state_nxt = ST_BEAT2;
      ST_BEAT2: begin
        w_cnt_clear = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_enable = 1'b1;
        // A done arriving in the timeout cycle still wins.
        if (done) begin
          w_rsp_result_nxt   = result;
          w_rsp_overflow_nxt = overflow;
          w_rsp_timeout_nxt  = 1'b0;
          w_state_nxt        = ST_RESP;
        end else if (w_expired) begin
          w_rsp_result_nxt   = '0;
          w_rsp_overflow_nxt = 1'b0;
          w_rsp_timeout_nxt  = 1'b1;
          w_state_nxt        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are registered, so they follow the state being entered.
    w_req_ready_nxt    = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt    = (w_state_nxt == ST_RESP);
    w_opcode_valid_nxt = (w_state_nxt == ST_BEAT0) || (w_state_nxt == ST_BEAT1) ||
                         (w_state_nxt == ST_BEAT2);
    w_opcode_nxt       = beat_opcode_bit(w_state_nxt, w_op_nxt);
    case (w_state_nxt)
      ST_BEAT0, ST_BEAT1: w_data_nxt = w_a_nxt;
      ST_BEAT2:           w_data_nxt = w_b_nxt;
      default:            w_data_nxt = '0;
    endcase
  end

  // State, captured request and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_ADD;
      r_a            <= '0;
      r_b            <= '0;
      r_req_ready    <= 1'b0;
      r_opcode_valid <= 1'b0;
      r_opcode       <= 1'b0;
      r_data         <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op           <= w_op_nxt;
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_opcode_valid <= w_opcode_valid_nxt;
      r_opcode       <= w_opcode_nxt;
      r_data         <= w_data_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_result   <= w_rsp_result_nxt;
      r_rsp_overflow <= w_rsp_overflow_nxt;
      r_rsp_timeout  <= w_rsp_timeout_nxt;
    end
  end

  assign req_ready    = r_req_ready;
  assign opcode_valid = r_opcode_valid;
  assign opcode       = r_opcode;
  assign data         = r_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_timeout  = r_rsp_timeout;

endmodule

// File: tb/tb_alu_driver.sv
// Directed self-checking bench for alu_driver with a small behavioural ALU.
module tb_alu_driver;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_opcode = 2'b00;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          opcode_valid;
  logic          opcode;
  logic [DW-1:0] data;
  logic          done = 1'b0;
  logic [DW-1:0] result = '0;
  logic          overflow = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ALU model controls (written by tests) and its observations.
  int            alu_delay = 1;
  logic          alu_sum = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic          alu_ovf = 1'b0;
  int            beat_cnt = 0;
  int            wait_cnt = 0;
  int            beat_total = 0;
  int            bcyc0 = 0;
  logic [DW-1:0] bdata [3];
  logic          bop [3];

  alu_driver #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: records beats, pulses done alu_delay cycles after the third beat.
  initial begin
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (reset) begin
        beat_cnt = 0;
        wait_cnt = 0;
      end else begin
        if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            done = 1'b1;
            if (alu_sum) {overflow, result} = 9'(bdata[0]) + 9'(bdata[2]);
            else begin
              result   = alu_result;
              overflow = alu_ovf;
            end
          end
        end
        if (opcode_valid) begin
          if (beat_cnt < 3) begin
            bdata[beat_cnt] = data;
            bop[beat_cnt]   = opcode;
          end
          if (beat_cnt == 0) bcyc0 = cyc;
          beat_cnt++;
          beat_total++;
          if (beat_cnt == 3) wait_cnt = alu_delay;
        end else begin
          beat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int acc_cyc);
    int n;
    n = 0;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_rsp(input int budget, output int rcyc);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    rcyc = cyc;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within %0d cycles", rsp_valid, budget);
    end
  endtask

  task automatic ack_rsp(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_ack: rsp_valid,req_ready=%b required 01", name, {rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, opcode_valid, opcode, rsp_valid, rsp_overflow, rsp_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {req_ready, opcode_valid, opcode, rsp_valid, rsp_overflow, rsp_timeout});
    end
    checks++;
    if ({data, rsp_result} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: data=%h rsp_result=%h required 00 00", data, rsp_result);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_add();
    int acc, rc, bt;
    alu_sum = 1'b0; alu_delay = 4; alu_result = 8'h08; alu_ovf = 1'b0;
    bt = beat_total;
    send_req(2'b00, 8'h05, 8'h03, acc);
    wait_rsp(30, rc);
    checks++;
    if ({bdata[0], bdata[1], bdata[2]} !== 24'h050503) begin
      errors++;
      $display("FAIL add_beat_data: %h %h %h required 05 05 03", bdata[0], bdata[1], bdata[2]);
    end
    checks++;
    if ({bop[0], bop[1], bop[2]} !== 3'b000) begin
      errors++;
      $display("FAIL add_beat_op: %b required 000", {bop[0], bop[1], bop[2]});
    end
    checks++;
    if (bcyc0 != acc || beat_total - bt != 3) begin
      errors++;
      $display("FAIL add_beat_timing: first beat cyc %0d (req %0d), beats %0d required 3",
               bcyc0, acc, beat_total - bt);
    end
    checks++;
    if ({rsp_result, rsp_overflow, rsp_timeout} !== {8'h08, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp: result=%h ovf=%b to=%b required 08 0 0",
               rsp_result, rsp_overflow, rsp_timeout);
    end
    checks++;
    if (rc != acc + 7) begin
      errors++;
      $display("FAIL add_latency: rsp at %0d required %0d", rc, acc + 7);
    end
    ack_rsp("add");
  endtask

  task automatic test_sub_ovf();
    int acc, rc;
    alu_sum = 1'b0; alu_delay = 1; alu_result = 8'h7F; alu_ovf = 1'b1;
    send_req(2'b01, 8'h80, 8'h01, acc);
    wait_rsp(30, rc);
    checks++;
    if ({bdata[0], bdata[1], bdata[2]} !== 24'h808001) begin
      errors++;
      $display("FAIL sub_beat_data: %h %h %h required 80 80 01", bdata[0], bdata[1], bdata[2]);
    end
    checks++;
    if ({bop[0], bop[1], bop[2]} !== 3'b110) begin
      errors++;
      $display("FAIL sub_beat_op: %b required 110", {bop[0], bop[1], bop[2]});
    end
    checks++;
    if ({rsp_result, rsp_overflow, rsp_timeout} !== {8'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_rsp: result=%h ovf=%b to=%b required 7f 1 0",
               rsp_result, rsp_overflow, rsp_timeout);
    end
    checks++;
    if (rc != acc + 4) begin
      errors++;
      $display("FAIL sub_min_latency: rsp at %0d required %0d", rc, acc + 4);
    end
    ack_rsp("sub");
  endtask

  task automatic test_timeout();
    int acc, rc;
    // done arrives 12 cycles after BEAT2: after the TIMEOUT=8 expiry, while the response waits.
    alu_sum = 1'b0; alu_delay = 12; alu_result = 8'hAA; alu_ovf = 1'b1;
    send_req(2'b00, 8'h11, 8'h22, acc);
    wait_rsp(40, rc);
    checks++;
    if (rc != acc + 2 + 9) begin
      errors++;
      $display("FAIL timeout_latency: rsp at %0d required %0d", rc, acc + 11);
    end
    checks++;
    if ({rsp_result, rsp_overflow, rsp_timeout} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp: result=%h ovf=%b to=%b required 00 0 1",
               rsp_result, rsp_overflow, rsp_timeout);
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_overflow, rsp_timeout} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_late_done: valid=%b result=%h ovf=%b to=%b required 1 00 0 1",
               rsp_valid, rsp_result, rsp_overflow, rsp_timeout);
    end
    ack_rsp("timeout");
  endtask

  task automatic test_backpressure();
    int acc, rc, bt;
    alu_sum = 1'b0; alu_delay = 1; alu_result = 8'h01; alu_ovf = 1'b0;
    send_req(2'b11, 8'h10, 8'h20, acc);
    wait_rsp(30, rc);
    bt = beat_total;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, req_ready, opcode_valid, rsp_result, rsp_overflow, rsp_timeout} !==
          {1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdy=%b ov=%b res=%h ovf=%b to=%b required 1 0 0 01 0 0",
                 i, rsp_valid, req_ready, opcode_valid, rsp_result, rsp_overflow, rsp_timeout);
      end
      if (i == 4) begin
        req_opcode = 2'b00; req_a = 8'h55; req_b = 8'h66; req_valid = 1'b1;
      end
      if (i == 5) req_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (beat_total != bt) begin
      errors++;
      $display("FAIL backpressure_no_accept: %0d beats seen required 0", beat_total - bt);
    end
    ack_rsp("backpressure");
  endtask

  task automatic test_reset_mid();
    int acc, rc;
    alu_sum = 1'b0; alu_delay = 1; alu_result = 8'h01; alu_ovf = 1'b0;
    send_req(2'b10, 8'h07, 8'h09, acc);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({opcode_valid, req_ready, data} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_async: ov=%b rdy=%b data=%h required 0 0 00",
               opcode_valid, req_ready, data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    send_req(2'b10, 8'h07, 8'h09, acc);
    wait_rsp(30, rc);
    checks++;
    if ({bdata[0], bdata[1], bdata[2], bop[0], bop[1], bop[2]} !== {24'h070709, 3'b001}) begin
      errors++;
      $display("FAIL par_beats: %h %h %h op %b required 07 07 09 op 001",
               bdata[0], bdata[1], bdata[2], {bop[0], bop[1], bop[2]});
    end
    checks++;
    if ({rsp_result, rsp_overflow, rsp_timeout} !== {8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL par_rsp: result=%h ovf=%b to=%b required 01 0 0",
               rsp_result, rsp_overflow, rsp_timeout);
    end
    ack_rsp("par");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] va [4];
    logic [DW-1:0] vb [4];
    logic [DW-1:0] er [4];
    logic          eo [4];
    logic [DW-1:0] rr [4];
    logic          ro [4];
    int            rc [4];
    int ri, qi, n;
    va[0] = 8'h01; vb[0] = 8'h02; er[0] = 8'h03; eo[0] = 1'b0;
    va[1] = 8'h10; vb[1] = 8'h20; er[1] = 8'h30; eo[1] = 1'b0;
    va[2] = 8'h7F; vb[2] = 8'h01; er[2] = 8'h80; eo[2] = 1'b0;
    va[3] = 8'hFF; vb[3] = 8'h01; er[3] = 8'h00; eo[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr[i] = '0; ro[i] = 1'b0; rc[i] = 0;
    end
    ri = 0; qi = 0; n = 0;
    alu_sum = 1'b1; alu_delay = 1;
    rsp_ready = 1'b1;
    req_opcode = 2'b00; req_a = va[0]; req_b = vb[0]; req_valid = 1'b1;
    while (ri < 4 && n < 80) begin
      if (rsp_valid === 1'b1) begin
        rr[ri] = rsp_result; ro[ri] = rsp_overflow; rc[ri] = cyc; ri++;
      end
      if (req_ready === 1'b1 && qi < 4) qi++;
      @(negedge clk);
      n++;
      if (qi < 4) begin
        req_a = va[qi]; req_b = vb[qi];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (ri != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d responses required 4", ri);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rr[i], ro[i]} !== {er[i], eo[i]}) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: result=%h ovf=%b required %h %b", i, rr[i], ro[i], er[i], eo[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (rc[i] - rc[i-1] != 6) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: %0d cycles required 6", i, rc[i] - rc[i-1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_ovf();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
